gif_frame_scheduler: RTL and testbench

Sequences the animation frames displayed by the LED panel. It selects which stored GIF frame the memory presents to the scan datapath, and it holds each frame for a programmable number of complete panel refreshes. Frame changes are aligned to the scan controller's end-of-refresh pulse, so the panel never shows two frames in one refresh. It replaces the free-running frame timer with play, pause, stop and step control, loop and one-shot modes, and per-frame durations.

---
 rtl/gif_sched_pkg.sv | 17 +
 rtl/gif_hold_table.sv | 38 +++
 rtl/gif_frame_scheduler.sv | 170 +++++++++++++++++
 tb/tb_gif_frame_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gif_sched_pkg.sv
// Shared types and constants for the GIF frame scheduler.
package gif_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_LOOP     = 2'd0;
    localparam logic [1:0] MODE_ONESHOT  = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    localparam int HOLD_W_DEF = 8;

endpackage

// File: rtl/gif_hold_table.sv
// Per-frame hold table: refresh count each frame stays on the panel.
module gif_hold_table
    import gif_sched_pkg::*;
#(
    parameter int TOTAL_FRAMES = 4,
    parameter int FRAME_W      = 2,
    parameter int HOLD_W       = HOLD_W_DEF,
    parameter int DEFAULT_HOLD = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [FRAME_W-1:0] waddr,
    input  logic [HOLD_W-1:0]  wdata,
    input  logic [FRAME_W-1:0] raddr,
    output logic [HOLD_W-1:0]  rdata
);

    logic [HOLD_W-1:0] mem [TOTAL_FRAMES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TOTAL_FRAMES; i++) begin
                mem[i] <= HOLD_W'(DEFAULT_HOLD);
            end
        end else if (we && (int'(waddr) < TOTAL_FRAMES)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (int'(raddr) < TOTAL_FRAMES) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/gif_frame_scheduler.sv
// Refresh-aligned GIF frame sequencer with play/pause/stop/step control.
// Ping-pong mode is built only when GIF_SCHED_PINGPONG_EN is defined.
module gif_frame_scheduler
    import gif_sched_pkg::*;
#(
    parameter int TOTAL_FRAMES = 4,
    parameter int FRAME_W      = 2,
    parameter int HOLD_W       = HOLD_W_DEF,
    parameter int DEFAULT_HOLD = 30,
    parameter bit AUTOPLAY     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               refresh_done,
    input  logic               play,
    input  logic               stop,
    input  logic               pause,
    input  logic               step,
    input  logic [1:0]         mode,
    input  logic               cfg_we,
    input  logic [FRAME_W-1:0] cfg_addr,
    input  logic [HOLD_W-1:0]  cfg_hold,
    output logic [FRAME_W-1:0] frame_sel,
    output logic               frame_changed,
    output logic               playing,
    output logic               done
);

    localparam logic [FRAME_W-1:0] LAST = FRAME_W'(TOTAL_FRAMES - 1);
    localparam state_t RST_STATE = AUTOPLAY ? ST_PLAY : ST_IDLE;

    state_t             state, state_n;
    logic [FRAME_W-1:0] frame_n, adv_frame;
    logic [HOLD_W-1:0]  cnt, cnt_n, hold, eff_hold;
    logic [HOLD_W:0]    cnt_inc;
    logic               pend, pend_n, chg_n;
    logic               adv_end, do_adv, hold_due;
`ifdef GIF_SCHED_PINGPONG_EN
    logic               dir, dir_n, adv_dir;
`endif

    gif_hold_table #(
        .TOTAL_FRAMES (TOTAL_FRAMES),
        .FRAME_W      (FRAME_W),
        .HOLD_W       (HOLD_W),
        .DEFAULT_HOLD (DEFAULT_HOLD)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_hold),
        .raddr (frame_sel),
        .rdata (hold)
    );

    assign eff_hold = (hold == '0) ? HOLD_W'(1) : hold;
    assign cnt_inc  = {1'b0, cnt} + 1'b1;
    assign hold_due = cnt_inc >= {1'b0, eff_hold};

    always_comb begin
        adv_frame = (frame_sel == LAST) ? '0 : frame_sel + 1'b1;
        adv_end   = 1'b0;
`ifdef GIF_SCHED_PINGPONG_EN
        adv_dir   = 1'b0;
`endif
        if (mode == MODE_ONESHOT && frame_sel == LAST) begin
            adv_frame = frame_sel;
            adv_end   = 1'b1;
        end
`ifdef GIF_SCHED_PINGPONG_EN
        if (mode == MODE_PINGPONG) begin
            // dir=1 walks down; the end frames turn around without repeating
            if (LAST == '0) begin
                adv_frame = '0;
            end else if (!dir) begin
                adv_dir   = (frame_sel == LAST);
                adv_frame = adv_dir ? frame_sel - 1'b1 : frame_sel + 1'b1;
            end else begin
                adv_dir   = (frame_sel != '0);
                adv_frame = adv_dir ? frame_sel - 1'b1 : frame_sel + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_n = state;
        frame_n = frame_sel;
        cnt_n   = cnt;
        pend_n  = pend;
        chg_n   = 1'b0;
        do_adv  = 1'b0;
`ifdef GIF_SCHED_PINGPONG_EN
        dir_n   = (mode == MODE_PINGPONG) ? dir : 1'b0;
`endif
        if (stop) begin
            state_n = ST_IDLE;
            frame_n = '0;
            cnt_n   = '0;
            pend_n  = 1'b0;
            chg_n   = (frame_sel != '0);
`ifdef GIF_SCHED_PINGPONG_EN
            dir_n   = 1'b0;
`endif
        end else if (pause && state == ST_PLAY) begin
            state_n = ST_PAUSE;
        end else if (play && state != ST_PLAY) begin
            state_n = ST_PLAY;
            pend_n  = 1'b0;
            if (state == ST_DONE) begin
                frame_n = '0;
                cnt_n   = '0;
                chg_n   = (frame_sel != '0);
`ifdef GIF_SCHED_PINGPONG_EN
                dir_n   = 1'b0;
`endif
            end
        end else if (step && (state == ST_IDLE || state == ST_PAUSE)) begin
            pend_n = 1'b1;
            cnt_n  = '0;
        end else if (refresh_done) begin
            if (state == ST_PLAY) begin
                do_adv = hold_due;
                cnt_n  = hold_due ? '0 : cnt_inc[HOLD_W-1:0];
            end else if (pend && (state == ST_IDLE || state == ST_PAUSE)) begin
                do_adv = 1'b1;
                pend_n = 1'b0;
            end
        end

        if (do_adv) begin
            if (adv_end) begin
                if (state == ST_PLAY) state_n = ST_DONE;
            end else begin
                frame_n = adv_frame;
                chg_n   = 1'b1;
`ifdef GIF_SCHED_PINGPONG_EN
                dir_n   = adv_dir;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RST_STATE;
            frame_sel     <= '0;
            cnt           <= '0;
            pend          <= 1'b0;
            frame_changed <= 1'b0;
`ifdef GIF_SCHED_PINGPONG_EN
            dir           <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            frame_sel     <= frame_n;
            cnt           <= cnt_n;
            pend          <= pend_n;
            frame_changed <= chg_n;
`ifdef GIF_SCHED_PINGPONG_EN
            dir           <= dir_n;
`endif
        end
    end

    assign playing = (state == ST_PLAY);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_gif_frame_scheduler.sv
// Scoreboard bench for gif_frame_scheduler (TOTAL_FRAMES=4, AUTOPLAY=1).
module tb_gif_frame_scheduler;

    localparam int FW = 2;
    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          refresh_done = 1'b0;
    logic          play = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          step = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          cfg_we = 1'b0;
    logic [FW-1:0] cfg_addr = '0;
    logic [HW-1:0] cfg_hold = '0;
    logic [FW-1:0] frame_sel;
    logic          frame_changed;
    logic          playing;
    logic          done;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int e;

    always #5 clk = ~clk;

    gif_frame_scheduler #(
        .TOTAL_FRAMES (4),
        .FRAME_W      (FW),
        .HOLD_W       (HW),
        .DEFAULT_HOLD (30),
        .AUTOPLAY     (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .refresh_done  (refresh_done),
        .play          (play),
        .stop          (stop),
        .pause         (pause),
        .step          (step),
        .mode          (mode),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_hold      (cfg_hold),
        .frame_sel     (frame_sel),
        .frame_changed (frame_changed),
        .playing       (playing),
        .done          (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every frame_changed pulse must match the next queued frame.
    always @(negedge clk) begin
        if (!rst && frame_changed) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: frame_sel=%0d expected no pulse",
                         frame_sel);
            end else begin
                e = exp_q.pop_front();
                if (int'(frame_sel) != e) begin
                    failures++;
                    $display("FAIL change_frame: got %0d expected %0d",
                             frame_sel, e);
                end
            end
        end
    end

    task automatic cmd(input bit p, input bit s, input bit pa,
                       input bit st, input int exp_chg);
        @(posedge clk); #1;
        play = p; stop = s; pause = pa; step = st;
        if (exp_chg >= 0) exp_q.push_back(exp_chg);
        @(posedge clk); #1;
        play = 0; stop = 0; pause = 0; step = 0;
    endtask

    task automatic refresh(input int exp_frame, input bit changes);
        @(posedge clk); #1;
        refresh_done = 1'b1;
        if (changes) exp_q.push_back(exp_frame);
        @(posedge clk); #1;
        refresh_done = 1'b0;
        chk("frame_after_refresh", int'(frame_sel), exp_frame);
    endtask

    task automatic wr(input int addr, input int h);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = FW'(addr); cfg_hold = HW'(h);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic all_holds(input int h);
        for (int i = 0; i < 4; i++) wr(i, h);
    endtask

    initial begin
        int pp[8];
`ifdef GIF_SCHED_PINGPONG_EN
        pp = '{1, 2, 3, 2, 1, 0, 1, 2};
`else
        pp = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
        #12;
        chk("reset_frame", int'(frame_sel), 0);
        chk("reset_changed", int'(frame_changed), 0);
        chk("reset_playing", int'(playing), 1);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;

        // loop, hold 2: frame advances on every second refresh
        mode = 2'd0;
        all_holds(2);
        for (int k = 1; k <= 8; k++) refresh((k / 2) % 4, (k % 2) == 0);

        // one-shot, hold 1
        mode = 2'd1;
        all_holds(1);
        refresh(1, 1);
        refresh(2, 1);
        refresh(3, 1);
        refresh(3, 0);
        chk("oneshot_done", int'(done), 1);
        chk("oneshot_not_playing", int'(playing), 0);
        cmd(1, 0, 0, 0, 0);
        chk("restart_frame", int'(frame_sel), 0);
        chk("restart_playing", int'(playing), 1);
        chk("restart_done", int'(done), 0);

        // pause mid-hold, step, resume
        mode = 2'd0;
        all_holds(5);
        refresh(0, 0);
        refresh(0, 0);
        cmd(0, 0, 1, 0, -1);
        chk("paused", int'(playing), 0);
        for (int k = 0; k < 10; k++) refresh(0, 0);
        cmd(0, 0, 0, 1, -1);
        refresh(1, 1);
        chk("step_still_paused", int'(playing), 0);
        cmd(1, 0, 0, 0, -1);
        chk("resumed", int'(playing), 1);
        for (int k = 0; k < 4; k++) refresh(1, 0);
        refresh(2, 1);

        // hold 0 acts as 1
        all_holds(2);
        wr(1, 0);
        refresh(2, 0);
        refresh(3, 1);
        refresh(3, 0);
        refresh(0, 1);
        refresh(0, 0);
        refresh(1, 1);
        refresh(2, 1);

        // write to current frame coincident with refresh uses old hold
        @(posedge clk); #1;
        refresh_done = 1'b1;
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_hold = 8'd1;
        @(posedge clk); #1;
        refresh_done = 1'b0; cfg_we = 1'b0;
        chk("old_hold_used", int'(frame_sel), 2);
        refresh(3, 1);

        // stop beats play and step
        cmd(1, 1, 0, 1, 0);
        chk("stop_frame", int'(frame_sel), 0);
        chk("stop_idle", int'(playing), 0);
        chk("stop_not_done", int'(done), 0);
        cmd(0, 1, 0, 0, -1);
        chk("stop_at_zero", int'(frame_sel), 0);

        // mode 2
        all_holds(1);
        mode = 2'd2;
        cmd(1, 0, 0, 0, -1);
        for (int k = 0; k < 8; k++) refresh(pp[k], 1);

        // step from idle, then async reset mid-hold
        cmd(0, 1, 0, 0, (pp[7] != 0) ? 0 : -1);
        mode = 2'd0;
        cmd(0, 0, 0, 1, -1);
        refresh(1, 1);
        chk("idle_step", int'(playing), 0);
        cmd(1, 0, 0, 0, -1);
        wr(1, 5);
        refresh(1, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_frame", int'(frame_sel), 0);
        chk("async_rst_changed", int'(frame_changed), 0);
        chk("async_rst_playing", int'(playing), 1);
        chk("async_rst_done", int'(done), 0);
        #20;
        rst = 1'b0;
        refresh(0, 0);
        refresh(0, 0);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
